// File: rtl/mips_tb_pkg.sv
// Shared state encoding and vector-entry layout for the MIPS vector checker.
// An entry is packed as {stim, expected, mask} with the mask in the low bits.
package mips_tb_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        APPLY = 2'd1,
        CHECK = 2'd2,
        DONE  = 2'd3
    } chkState_e;

    localparam logic [15:0] ERR_MAX = 16'hFFFF;

    function automatic int entryWidth(input int stimW, input int expW);
        return stimW + 2 * expW;
    endfunction

    function automatic int stimLsb(input int expW);
        return 2 * expW;
    endfunction

    function automatic int expLsb(input int expW);
        return expW;
    endfunction

    function automatic int maskLsb();
        return 0;
    endfunction

endpackage

// File: rtl/mips_vector_ram.sv
// Vector storage: one synchronous write port, one asynchronous read port.
// Contents survive reset so a run can be repeated without reloading.
module mips_vector_ram #(
    parameter  int WIDTH  = 40,
    parameter  int DEPTH  = 64,
    localparam int ADDR_W = $clog2(DEPTH)
) (
    input  logic              clk,
    input  logic              wr_en_i,
    input  logic [ADDR_W-1:0] wr_addr_i,
    input  logic [WIDTH-1:0]  wr_data_i,
    input  logic [ADDR_W-1:0] rd_addr_i,
    output logic [WIDTH-1:0]  rd_data_o
);

    logic [WIDTH-1:0] mem_q [DEPTH];

    always_ff @(posedge clk) begin
        if (wr_en_i) begin
            mem_q[wr_addr_i] <= wr_data_i;
        end
    end

    assign rd_data_o = mem_q[rd_addr_i];

endmodule

// File: rtl/mips_vector_checker.sv
// Replays stored stimulus vectors, waits SETTLE cycles per vector and compares
// the observed value against the masked expectation, tracking error statistics.
module mips_vector_checker
    import mips_tb_pkg::*;
#(
    parameter  int STIM_W  = 8,
    parameter  int EXP_W   = 32,
    parameter  int DEPTH   = 64,
    parameter  int SETTLE  = 1,
    localparam int ADDR_W  = $clog2(DEPTH),
    localparam int ENTRY_W = entryWidth(STIM_W, EXP_W)
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    input  logic              stop_on_err,
    input  logic              load_en,
    input  logic [ADDR_W-1:0] load_addr,
    input  logic [ENTRY_W-1:0] load_data,
    input  logic [ADDR_W:0]   num_vec,
    input  logic [EXP_W-1:0]  obs,
    output logic [STIM_W-1:0] stim,
    output logic              busy,
    output logic              done,
    output logic              pass,
    output logic [15:0]       err_count,
    output logic [ADDR_W-1:0] first_err_idx,
    output logic [EXP_W-1:0]  first_err_obs,
    output logic [ADDR_W-1:0] vec_idx
);

    localparam int CountW   = ADDR_W + 1;
    localparam int SetW     = (SETTLE > 1) ? $clog2(SETTLE) : 1;
    localparam int StimLsb  = stimLsb(EXP_W);
    localparam int ExpLsb   = expLsb(EXP_W);
    localparam int MaskLsb  = maskLsb();

    chkState_e         state_q, state_d;
    logic              startPend_q, startPend_d;
    logic [CountW-1:0] count_q, count_d;
    logic              stopOnErr_q, stopOnErr_d;
    logic [ADDR_W-1:0] vecIdx_q, vecIdx_d;
    logic [SetW-1:0]   settleCnt_q, settleCnt_d;
    logic [STIM_W-1:0] stim_q, stim_d;
    logic [EXP_W-1:0]  expected_q, expected_d;
    logic [EXP_W-1:0]  mask_q, mask_d;
    logic [15:0]       errCount_q, errCount_d;
    logic              firstSeen_q, firstSeen_d;
    logic [ADDR_W-1:0] firstErrIdx_q, firstErrIdx_d;
    logic [EXP_W-1:0]  firstErrObs_q, firstErrObs_d;

    logic              memWrEn;
    logic [ADDR_W-1:0] rdAddr;
    logic [ENTRY_W-1:0] rdEntry;
    logic [STIM_W-1:0] rdStim;
    logic [EXP_W-1:0]  rdExp;
    logic [EXP_W-1:0]  rdMask;
    logic [CountW-1:0] numClamped;
    logic              mismatch;
    logic              lastVec;

    assign memWrEn = load_en && ((state_q == IDLE) || (state_q == DONE));

    // The only read ever needed is the entry about to be applied: vector 0 on
    // the first APPLY, otherwise the one after the vector being checked.
    assign rdAddr = (state_q == CHECK) ? ADDR_W'(vecIdx_q + 1'b1) : '0;

    mips_vector_ram #(
        .WIDTH(ENTRY_W),
        .DEPTH(DEPTH)
    ) u_ram (
        .clk      (clk),
        .wr_en_i  (memWrEn),
        .wr_addr_i(load_addr),
        .wr_data_i(load_data),
        .rd_addr_i(rdAddr),
        .rd_data_o(rdEntry)
    );

    assign rdStim     = rdEntry[StimLsb +: STIM_W];
    assign rdExp      = rdEntry[ExpLsb +: EXP_W];
    assign rdMask     = rdEntry[MaskLsb +: EXP_W];
    assign numClamped = (num_vec > CountW'(DEPTH)) ? CountW'(DEPTH) : num_vec;
    assign mismatch   = ((obs ^ expected_q) & mask_q) != '0;
    assign lastVec    = ({1'b0, vecIdx_q} == (count_q - 1'b1));

    always_comb begin
        state_d       = state_q;
        startPend_d   = 1'b0;
        count_d       = count_q;
        stopOnErr_d   = stopOnErr_q;
        vecIdx_d      = vecIdx_q;
        settleCnt_d   = settleCnt_q;
        stim_d        = stim_q;
        expected_d    = expected_q;
        mask_d        = mask_q;
        errCount_d    = errCount_q;
        firstSeen_d   = firstSeen_q;
        firstErrIdx_d = firstErrIdx_q;
        firstErrObs_d = firstErrObs_q;

        unique case (state_q)
            IDLE, DONE: begin
                // A start takes one cycle in IDLE to clear results before the first vector.
                if (start) begin
                    state_d       = IDLE;
                    startPend_d   = 1'b1;
                    count_d       = numClamped;
                    stopOnErr_d   = stop_on_err;
                    vecIdx_d      = '0;
                    errCount_d    = '0;
                    firstSeen_d   = 1'b0;
                    firstErrIdx_d = '0;
                    firstErrObs_d = '0;
                end else if (startPend_q) begin
                    if (count_q == '0) begin
                        state_d = DONE;
                    end else begin
                        state_d     = APPLY;
                        settleCnt_d = '0;
                        stim_d      = rdStim;
                        expected_d  = rdExp;
                        mask_d      = rdMask;
                    end
                end
            end
            APPLY: begin
                if (settleCnt_q == SetW'(SETTLE - 1)) begin
                    state_d = CHECK;
                end else begin
                    settleCnt_d = settleCnt_q + 1'b1;
                end
            end
            CHECK: begin
                if (mismatch) begin
                    errCount_d = (errCount_q == ERR_MAX) ? errCount_q : errCount_q + 16'd1;
                    if (!firstSeen_q) begin
                        firstSeen_d   = 1'b1;
                        firstErrIdx_d = vecIdx_q;
                        firstErrObs_d = obs;
                    end
                end
                if (lastVec || (stopOnErr_q && mismatch)) begin
                    state_d = DONE;
                end else begin
                    state_d     = APPLY;
                    vecIdx_d    = ADDR_W'(vecIdx_q + 1'b1);
                    settleCnt_d = '0;
                    stim_d      = rdStim;
                    expected_d  = rdExp;
                    mask_d      = rdMask;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q       <= IDLE;
            startPend_q   <= 1'b0;
            count_q       <= '0;
            stopOnErr_q   <= 1'b0;
            vecIdx_q      <= '0;
            settleCnt_q   <= '0;
            stim_q        <= '0;
            expected_q    <= '0;
            mask_q        <= '0;
            errCount_q    <= '0;
            firstSeen_q   <= 1'b0;
            firstErrIdx_q <= '0;
            firstErrObs_q <= '0;
        end else begin
            state_q       <= state_d;
            startPend_q   <= startPend_d;
            count_q       <= count_d;
            stopOnErr_q   <= stopOnErr_d;
            vecIdx_q      <= vecIdx_d;
            settleCnt_q   <= settleCnt_d;
            stim_q        <= stim_d;
            expected_q    <= expected_d;
            mask_q        <= mask_d;
            errCount_q    <= errCount_d;
            firstSeen_q   <= firstSeen_d;
            firstErrIdx_q <= firstErrIdx_d;
            firstErrObs_q <= firstErrObs_d;
        end
    end

    assign stim          = stim_q;
    assign busy          = (state_q == APPLY) || (state_q == CHECK);
    assign done          = (state_q == DONE);
    assign pass          = (state_q == DONE) && (errCount_q == '0);
    assign err_count     = errCount_q;
    assign first_err_idx = firstErrIdx_q;
    assign first_err_obs = firstErrObs_q;
    assign vec_idx       = vecIdx_q;

endmodule

// File: tb/tb_mips_vector_checker.sv
// Self-checking bench for mips_vector_checker (STIM_W=8, EXP_W=8, DEPTH=16, SETTLE=2).
// A run-level timeline model is compared against the DUT every cycle.
module tb_mips_vector_checker;

    localparam int STIM_W = 8;
    localparam int EXP_W  = 8;
    localparam int DEPTH  = 16;
    localparam int SETTLE = 2;
    localparam int PER    = SETTLE + 1;

    logic        clk;
    logic        reset;
    logic        start;
    logic        stopOnErr;
    logic        loadEn;
    logic [3:0]  loadAddr;
    logic [23:0] loadData;
    logic [4:0]  numVec;
    logic [7:0]  obs;
    logic [7:0]  stim;
    logic        busy;
    logic        done;
    logic        pass;
    logic [15:0] errCount;
    logic [3:0]  firstErrIdx;
    logic [7:0]  firstErrObs;
    logic [3:0]  vecIdx;

    mips_vector_checker #(
        .STIM_W(STIM_W),
        .EXP_W (EXP_W),
        .DEPTH (DEPTH),
        .SETTLE(SETTLE)
    ) dut (
        .clk          (clk),
        .reset        (reset),
        .start        (start),
        .stop_on_err  (stopOnErr),
        .load_en      (loadEn),
        .load_addr    (loadAddr),
        .load_data    (loadData),
        .num_vec      (numVec),
        .obs          (obs),
        .stim         (stim),
        .busy         (busy),
        .done         (done),
        .pass         (pass),
        .err_count    (errCount),
        .first_err_idx(firstErrIdx),
        .first_err_obs(firstErrObs),
        .vec_idx      (vecIdx)
    );

    // Emulated device: loops stim back, corrupted per vector (stim low nibble = index).
    logic [7:0] obsXor [16];
    assign obs = stim ^ obsXor[stim[3:0]];

    int vectorsApplied = 0;
    int missCount = 0;
    int cyc = 0;

    // Model state
    logic [7:0] mStim [16];
    logic [7:0] mExp  [16];
    logic [7:0] mMask [16];
    logic [7:0] mObs  [16];
    bit         mMis  [16];
    bit         modelOn = 1'b1;
    bit         modelIdle = 1'b1;
    int         startEdge = 0;
    int         runLen = 0;
    logic [7:0] prevStim = 8'h00;
    logic [7:0] lastStim = 8'h00;

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    always @(posedge clk) cyc <= cyc + 1;

    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
        vectorsApplied++;
        if (actual !== expected) begin
            missCount++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, actual, expected, $time);
        end
    endtask

    // Write one memory entry; called at a negedge, returns at the next negedge.
    task automatic applyStimulus(input int idx, input logic [7:0] s, input logic [7:0] e, input logic [7:0] m);
        loadEn   = 1'b1;
        loadAddr = idx[3:0];
        loadData = {s, e, m};
        mStim[idx] = s;
        mExp[idx]  = e;
        mMask[idx] = m;
        @(negedge clk);
        loadEn = 1'b0;
    endtask

    task automatic clearObsXor();
        for (int i = 0; i < 16; i++) obsXor[i] = 8'h00;
    endtask

    // Pulse start and precompute the whole run from the vector rules.
    task automatic startRun(input int num, input bit stop);
        int kMax;
        numVec    = num[4:0];
        stopOnErr = stop;
        start     = 1'b1;
        kMax = (num > DEPTH) ? DEPTH : num;
        runLen = kMax;
        for (int i = 0; i < kMax; i++) begin
            mObs[i] = mStim[i] ^ obsXor[i];
            mMis[i] = ((mObs[i] ^ mExp[i]) & mMask[i]) != 8'h00;
            if (stop && mMis[i]) begin
                runLen = i + 1;
                break;
            end
        end
        prevStim = lastStim;
        if (runLen > 0) lastStim = mStim[runLen-1];
        startEdge = cyc + 1;
        modelIdle = 1'b0;
        @(negedge clk);
        start = 1'b0;
    endtask

    task automatic waitDone(input int budget, output int latency);
        latency = -1;
        for (int i = 0; i < budget; i++) begin
            @(posedge clk);
            #2;
            if (done) begin
                latency = cyc - startEdge;
                break;
            end
        end
        if (latency < 0) checkOutput("done_timeout", 32'd0, 32'd1);
        @(negedge clk);
    endtask

    // Per-cycle comparison against the run timeline.
    initial begin : compareProc
        int c, nChecked, expErr, expFi, expVec;
        logic [7:0] expStim, expFo;
        logic expBusy, expDone;
        forever begin
            @(posedge clk);
            #2;
            if (modelOn) begin
                expBusy = 1'b0; expDone = 1'b0; expErr = 0; expFi = 0; expFo = 8'h00;
                expVec = 0; expStim = 8'h00; nChecked = 0;
                if (!modelIdle) begin
                    c = cyc - startEdge;
                    if (c <= 0) begin
                        expStim = prevStim;
                    end else if (c <= runLen * PER) begin
                        expBusy  = 1'b1;
                        nChecked = (c - 1) / PER;
                        expVec   = nChecked;
                        expStim  = mStim[nChecked];
                    end else begin
                        expDone  = 1'b1;
                        nChecked = runLen;
                        expVec   = (runLen > 0) ? runLen - 1 : 0;
                        expStim  = (runLen > 0) ? mStim[runLen-1] : prevStim;
                    end
                    for (int i = 0; i < nChecked; i++) begin
                        if (mMis[i]) begin
                            if (expErr == 0) begin
                                expFi = i;
                                expFo = mObs[i];
                            end
                            expErr++;
                        end
                    end
                end
                checkOutput("busy", busy, expBusy);
                checkOutput("done", done, expDone);
                checkOutput("pass", pass, expDone && (expErr == 0));
                checkOutput("err_count", errCount, expErr);
                checkOutput("first_err_idx", firstErrIdx, expFi);
                checkOutput("first_err_obs", firstErrObs, expFo);
                checkOutput("vec_idx", vecIdx, expVec);
                checkOutput("stim", stim, expStim);
            end
        end
    end

    initial begin : watchdog
        #200000;
        $display("[TB] FAIL watchdog: simulation did not finish, got timeout, expected completion");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin : mainProc
        int lat;
        start = 1'b0; stopOnErr = 1'b0; loadEn = 1'b0; loadAddr = '0; loadData = '0; numVec = '0;
        clearObsXor();
        reset = 1'b1;
        #1 reset = 1'b0;
        repeat (2) @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        checkOutput("rst_busy", busy, 1'b0);
        checkOutput("rst_done", done, 1'b0);
        checkOutput("rst_stim", stim, 8'h00);
        checkOutput("rst_err", errCount, 16'h0000);

        for (int i = 0; i < 16; i++) applyStimulus(i, 8'h50 + 8'(i), 8'h50 + 8'(i), 8'hFF);

        $display("[TB] loopback run of 4 vectors");
        startRun(4, 1'b0);
        waitDone(100, lat);
        checkOutput("s1_latency", lat, 13);
        checkOutput("s1_err", errCount, 0);
        checkOutput("s1_pass", pass, 1);
        checkOutput("s1_stim", stim, 8'h53);
        checkOutput("s1_vec", vecIdx, 3);

        $display("[TB] forced obs mismatch on vector 2");
        applyStimulus(2, 8'h52, 8'h55, 8'hFF);
        obsXor[2] = 8'h06;
        startRun(4, 1'b0);
        waitDone(100, lat);
        checkOutput("s2_err", errCount, 1);
        checkOutput("s2_fidx", firstErrIdx, 2);
        checkOutput("s2_fobs", firstErrObs, 8'h54);
        checkOutput("s2_pass", pass, 0);
        applyStimulus(2, 8'h52, 8'h55, 8'hFE);
        startRun(4, 1'b0);
        waitDone(100, lat);
        checkOutput("s2m_err", errCount, 0);
        checkOutput("s2m_pass", pass, 1);
        applyStimulus(2, 8'h52, 8'h52, 8'hFF);
        obsXor[2] = 8'h00;

        $display("[TB] stop on first error");
        obsXor[1] = 8'h01;
        obsXor[3] = 8'h01;
        startRun(4, 1'b1);
        waitDone(100, lat);
        checkOutput("s3_latency", lat, 7);
        checkOutput("s3_vec", vecIdx, 1);
        checkOutput("s3_err", errCount, 1);
        startRun(4, 1'b0);
        waitDone(100, lat);
        checkOutput("s3c_err", errCount, 2);
        checkOutput("s3c_fobs", firstErrObs, 8'h50);

        $display("[TB] zero and oversized counts");
        clearObsXor();
        startRun(0, 1'b0);
        waitDone(20, lat);
        checkOutput("s4_zero_latency", lat, 1);
        checkOutput("s4_zero_pass", pass, 1);
        startRun(20, 1'b0);
        waitDone(200, lat);
        checkOutput("s4_clamp_latency", lat, 49);
        checkOutput("s4_clamp_vec", vecIdx, 15);
        checkOutput("s4_clamp_stim", stim, 8'h5F);

        $display("[TB] reset during vector 2");
        obsXor[1] = 8'h01;
        startRun(6, 1'b0);
        repeat (8) @(negedge clk);
        reset = 1'b0;
        modelIdle = 1'b1;
        lastStim = 8'h00;
        #1;
        checkOutput("s5_rst_busy", busy, 1'b0);
        checkOutput("s5_rst_done", done, 1'b0);
        checkOutput("s5_rst_err", errCount, 16'h0000);
        repeat (2) @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        startRun(6, 1'b0);
        waitDone(100, lat);
        checkOutput("s5_latency", lat, 19);
        checkOutput("s5_err", errCount, 1);
        checkOutput("s5_fidx", firstErrIdx, 1);
        checkOutput("s5_fobs", firstErrObs, 8'h50);
        checkOutput("s5_vec", vecIdx, 5);

        $display("[TB] load and start while busy");
        clearObsXor();
        startRun(8, 1'b0);
        repeat (3) @(negedge clk);
        loadEn = 1'b1; loadAddr = 4'h0; loadData = 24'hFFFFFF;
        start = 1'b1; numVec = 5'd1; stopOnErr = 1'b1;
        @(negedge clk);
        loadEn = 1'b0; start = 1'b0;
        waitDone(100, lat);
        checkOutput("s6_latency", lat, 25);
        checkOutput("s6_err", errCount, 0);
        startRun(1, 1'b0);
        waitDone(20, lat);
        checkOutput("s6_mem_stim", stim, 8'h50);
        checkOutput("s6_mem_pass", pass, 1);

        $display("[TB] error counter saturation");
        for (int i = 0; i < 16; i++) obsXor[i] = 8'h01;
        modelOn = 1'b0;
        startRun(16, 1'b0);
        repeat (2) @(negedge clk);
        force dut.errCount_q = 16'hFFFD;
        #1;
        release dut.errCount_q;
        repeat (3) @(negedge clk);
        checkOutput("s7_err_mid", errCount, 16'hFFFE);
        waitDone(200, lat);
        checkOutput("s7_err_sat", errCount, 16'hFFFF);
        checkOutput("s7_fidx", firstErrIdx, 0);
        checkOutput("s7_fobs", firstErrObs, 8'h51);
        checkOutput("s7_pass", pass, 0);

        $display("== %0d vectors applied, %0d miscompares ==", vectorsApplied, missCount);
        $finish;
    end

endmodule

// File: doc/mips_vector_checker.md
MIPS_VECTOR_CHECKER -- requirements
Module: mips_vector_checker

Interface
REQ-001 STIM_W, default 8: width of the stimulus field driven to the DUT.
REQ-002 EXP_W, default 32: width of the expected, mask and observed fields.
REQ-003 DEPTH, default 64: number of vector entries; ADDR_W = $clog2(DEPTH).
REQ-004 SETTLE, default 1 (legal >= 1): cycles between applying a stimulus and sampling the observed value.
REQ-005 clk  input  1  single clock; all state changes on its rising edge.
REQ-006 reset  input  1  asynchronous, active-low reset.
REQ-007 start  input  1  one-cycle pulse that begins a run.
REQ-008 stop_on_err  input  1  end the run at the first mismatch; sampled at start.
REQ-009 load_en  input  1  write strobe for the vector memory.
REQ-010 load_addr  input  ADDR_W  vector memory write address.
REQ-011 load_data  input  STIM_W+2*EXP_W  {stim, expected, mask} entry.
REQ-012 num_vec  input  ADDR_W+1  vector count for the run; sampled at start.
REQ-013 obs  input  EXP_W  observed DUT value.
REQ-014 stim  output  STIM_W  registered stimulus to the DUT.
REQ-015 busy  output  1  high while in APPLY or CHECK.
REQ-016 done  output  1  high in DONE.
REQ-017 pass  output  1  high in DONE when err_count == 0.
REQ-018 err_count  output  16  mismatch count.
REQ-019 first_err_idx  output  ADDR_W  index of the first mismatching vector.
REQ-020 first_err_obs  output  EXP_W  obs value captured at the first mismatch.
REQ-021 vec_idx  output  ADDR_W  index of the current or last vector.

Function
REQ-022 States SHALL be IDLE, APPLY, CHECK and DONE.
REQ-023 load_en SHALL write mem[load_addr] only in IDLE or DONE; writes while busy are ignored.
REQ-024 start in IDLE or DONE SHALL clear err_count, first_err_*, and vec_idx, and latch num_vec clamped to DEPTH and stop_on_err; start while busy is ignored.
REQ-025 If the latched count is 0, start SHALL go directly to DONE on the next edge with pass=1.
REQ-026 Entering APPLY SHALL load stim from mem[vec_idx] on the same edge.
REQ-027 APPLY SHALL last SETTLE cycles, then go to CHECK.
REQ-028 CHECK SHALL last one cycle and evaluate mismatch = ((obs ^ expected) & mask) != 0.
REQ-029 Per-vector cost SHALL be SETTLE+1 cycles; a run of N vectors SHALL assert done N*(SETTLE+1)+1 cycles after the start edge.
REQ-030 On a mismatch, err_count SHALL increment, saturating at 16'hFFFF.
REQ-031 On the first mismatch of a run, first_err_idx and first_err_obs SHALL be captured; later mismatches leave them unchanged.
REQ-032 From CHECK, the FSM SHALL go to DONE if vec_idx == count-1 or (stop_on_err && mismatch); otherwise it SHALL increment vec_idx and go to APPLY.
REQ-033 DONE SHALL hold all results, stim and vec_idx until the next start.

Reset
REQ-034 Reset low SHALL immediately force IDLE, including mid-run.
REQ-035 Reset SHALL clear stim, busy, done, pass, err_count, first_err_idx, first_err_obs, vec_idx and the latched count/mode.
REQ-036 Vector memory contents SHALL NOT be reset.

Structure
REQ-037 Package mips_tb_pkg SHALL hold the state enum and the vector-entry packed-struct field layout helpers.
REQ-038 The memory SHALL be sub-module mips_vector_ram: one write port and one asynchronous read port, with no reset.

Verification (STIM_W=8, EXP_W=8, DEPTH=16, SETTLE=2)
REQ-039 Scenario: 4 vectors with expected=stim, mask=FF, obs looped back from stim, start -> done 13 cycles later, err_count 0, pass 1.
REQ-040 Scenario: vector 2 with expected 55, obs forced 54, mask FF -> err_count 1, first_err_idx 2, first_err_obs 54, pass 0; with mask FE -> err_count 0, pass 1.
REQ-041 Scenario: stop_on_err=1 with mismatches at vectors 1 and 3 -> done after vector 1, vec_idx 1, err_count 1.
REQ-042 Scenario: num_vec=0 -> done and pass on the next edge; num_vec=20 -> 16 vectors run and vec_idx ends at 15.
REQ-043 Scenario: reset low during vector 2 -> busy, done and err_count 0 immediately; restart with no reload gives results identical to a fresh run.
REQ-044 Scenario: load_en and start pulsed while busy -> memory and run unaffected; a 16'hFFFF saturation check uses a forced counter preload.
